// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock status into an ordered, glitch-free release of core reset domains.
// Runs entirely on the free-running reference clock that also feeds the PLL.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 32,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int LOCK_FILTER_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES      = 1024,
  parameter int NUM_STAGES          = 3,
  parameter int STAGE_GAP_CYCLES    = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] core_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [3:0]            retry_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_FILTER_CYCLES),
                                max2(HOLDOFF_CYCLES, STAGE_GAP_CYCLES));
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_FILTER,
    S_HOLDOFF,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [3:0]            retry_q, retry_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0] core_q, core_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic [1:0]            sync_q;

  logic                  locked_s;
  logic                  lock_lost;
  logic                  timed_out;
  logic [NUM_STAGES-1:0] core_shift;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  assign locked_s   = sync_q[1];
  assign lock_lost  = !locked_s &&
                      (state_q == S_HOLDOFF || state_q == S_RELEASE || state_q == S_RUN);
  assign timed_out  = (tmo_q >= TW'(LOCK_TIMEOUT_CYCLES - 1));
  // Releases only ever shift a one in from bit 0, so stages come up strictly in order.
  assign core_shift = (core_q << 1) | NUM_STAGES'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    core_d    = core_q;
    ready_d   = ready_q;
    fault_d   = fault_q;

    if (sw_reset_req) begin
      state_d   = S_PLL_RESET;
      cnt_d     = '0;
      tmo_d     = '0;
      retry_d   = '0;
      pll_rst_d = 1'b1;
      core_d    = '0;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
    end else if (lock_lost) begin
      state_d   = S_PLL_RESET;
      cnt_d     = '0;
      tmo_d     = '0;
      pll_rst_d = 1'b1;
      core_d    = '0;
      ready_d   = 1'b0;
    end else if ((state_q == S_WAIT_LOCK || state_q == S_FILTER) && timed_out) begin
      cnt_d     = '0;
      tmo_d     = '0;
      pll_rst_d = 1'b1;
      if (retry_q >= 4'(MAX_RETRIES - 1)) begin
        state_d = S_FAULT;
        retry_d = 4'(MAX_RETRIES);
        fault_d = 1'b1;
      end else begin
        state_d = S_PLL_RESET;
        retry_d = retry_q + 4'd1;
      end
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          pll_rst_d = 1'b1;
          core_d    = '0;
          ready_d   = 1'b0;
          if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
            state_d   = S_WAIT_LOCK;
            cnt_d     = '0;
            tmo_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          tmo_d = tmo_q + TW'(1);
          if (locked_s) begin
            // The cycle that first sees lock already counts toward the filter run.
            if (LOCK_FILTER_CYCLES <= 1) begin
              state_d = S_HOLDOFF;
              cnt_d   = '0;
            end else begin
              state_d = S_FILTER;
              cnt_d   = CW'(1);
            end
          end
        end
        S_FILTER: begin
          tmo_d = tmo_q + TW'(1);
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == CW'(LOCK_FILTER_CYCLES - 1)) begin
            state_d = S_HOLDOFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
            cnt_d  = '0;
            core_d = NUM_STAGES'(1);
            if (NUM_STAGES == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == CW'(STAGE_GAP_CYCLES - 1)) begin
            cnt_d  = '0;
            core_d = core_shift;
            if (&core_shift) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          core_d  = '1;
          ready_d = 1'b1;
        end
        S_FAULT: begin
          pll_rst_d = 1'b1;
          core_d    = '0;
          ready_d   = 1'b0;
          fault_d   = 1'b1;
        end
        default: begin
          state_d   = S_PLL_RESET;
          cnt_d     = '0;
          tmo_d     = '0;
          pll_rst_d = 1'b1;
          core_d    = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      core_q    <= '0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      core_q    <= core_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_rst_n  = core_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: bring-up, lock loss, filter glitch, timeout/fault, and simultaneous events.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic [2:0] core_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  int total = 0;
  int bad   = 0;
  int n;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(50), .LOCK_FILTER_CYCLES(4),
    .HOLDOFF_CYCLES(8), .NUM_STAGES(3), .STAGE_GAP_CYCLES(2), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst), .core_rst_n(core_rst_n), .ready(ready), .fault(fault),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return pll_rst;
      1: return core_rst_n[0];
      2: return core_rst_n[1];
      3: return core_rst_n[2];
      4: return ready;
      default: return fault;
    endcase
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Edges until the selected output first shows val; -1 if the bound expires.
  task automatic wait_sig(input int sel, input logic val, input int lim, output int cnt);
    cnt = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (sig(sel) === val) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0;
    #12;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core", core_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);
    tick();
    rst_n = 1'b1;

    // nominal bring-up
    wait_sig(0, 1'b0, 20, n);  chk("nom_prst_len", n, 4);
    repeat (6) tick();
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 40, n);  chk("nom_core0", n, 14);
    chk("nom_core0_only", core_rst_n, 3'b001);
    chk("nom_ready_early0", ready, 0);
    wait_sig(2, 1'b1, 10, n);  chk("nom_core1", n, 2);
    chk("nom_ready_early1", ready, 0);
    wait_sig(3, 1'b1, 10, n);  chk("nom_core2", n, 2);
    chk("nom_ready", ready, 1);
    chk("nom_retry", retry_count, 0);
    chk("nom_pll_rst", pll_rst, 0);

    // lock loss in RUN
    repeat (3) tick();
    pll_locked = 1'b0;
    wait_sig(4, 1'b0, 10, n);  chk("loss_lat", n, 3);
    chk("loss_core", core_rst_n, 0);
    chk("loss_pll_rst", pll_rst, 1);
    wait_sig(0, 1'b0, 10, n);  chk("loss_prst_len", n, 4);
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 40, n);  chk("relock_core0", n, 14);
    wait_sig(4, 1'b1, 10, n);  chk("relock_ready", n, 4);

    // lock glitch during FILTER
    pll_locked = 1'b0;
    sw_pulse();
    chk("sw_core", core_rst_n, 0);
    chk("sw_pll_rst", pll_rst, 1);
    wait_sig(0, 1'b0, 10, n);  chk("gl_prst_len", n, 4);
    pll_locked = 1'b1;
    tick(); tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 40, n);  chk("gl_core0", n, 14);

    // timeout retry then fault
    pll_locked = 1'b0;
    sw_pulse();
    wait_sig(0, 1'b0, 10, n);  chk("to_prst_len", n, 4);
    wait_sig(0, 1'b1, 80, n);  chk("to_first", n, 50);
    chk("to_retry1", retry_count, 1);
    chk("to_nofault", fault, 0);
    wait_sig(0, 1'b0, 10, n);  chk("to_repulse", n, 4);
    wait_sig(5, 1'b1, 80, n);  chk("to_fault", n, 50);
    chk("to_retry2", retry_count, 2);
    chk("to_pll_rst", pll_rst, 1);
    repeat (5) tick();
    chk("fault_hold", fault, 1);
    chk("fault_pll_rst", pll_rst, 1);
    sw_pulse();
    chk("clr_fault", fault, 0);
    chk("clr_retry", retry_count, 0);
    chk("clr_pll_rst", pll_rst, 1);
    wait_sig(0, 1'b0, 10, n);  chk("clr_prst_len", n, 4);

    // sw request coincides with lock loss during RELEASE
    wait_sig(0, 1'b1, 80, n);  chk("sim_timeout", n, 50);
    chk("sim_retry1", retry_count, 1);
    wait_sig(0, 1'b0, 10, n);  chk("sim_prst_len", n, 4);
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 40, n);  chk("sim_core0", n, 14);
    pll_locked = 1'b0;
    chk("sim_retry_rel", retry_count, 1);
    tick(); tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    chk("sim_core", core_rst_n, 0);
    chk("sim_ready", ready, 0);
    chk("sim_retry0", retry_count, 0);
    chk("sim_pll_rst", pll_rst, 1);
    chk("sim_fault", fault, 0);

    // async reset in the middle of RELEASE
    pll_locked = 1'b1;
    wait_sig(0, 1'b0, 10, n);  chk("ar_prst_len", n, 4);
    wait_sig(1, 1'b1, 40, n);  chk("ar_core0", n, 12);
    tick();
    chk("ar_mid_release", core_rst_n, 3'b001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_pll_rst", pll_rst, 1);
    chk("ar_core", core_rst_n, 0);
    chk("ar_ready", ready, 0);
    chk("ar_retry", retry_count, 0);
    #10;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
